icache_data_array: RTL
======================

Name: icache_data_array

Overview:
- Parametrised multi-way instruction-cache data store with a built-in line-refill sequencer.
- Sits between the ICache controller (lookup and refill requests) and the bus interface (refill beats).
- Provides a registered read of all ways at one set/word offset.
- Accepts a critical-word-first burst refill into one selected way, with write-to-read forwarding on collisions.

Parameters:
- WAYS, 2, number of ways; power of two, 1..8.
- SETS, 64, number of sets per way; power of two.
- LINE_WORDS, 8, 32-bit words per cache line; power of two, 2..16.
- DATA_W, 32, word width in bits.
- Derived: WAY_W=max(1,clog2(WAYS)), IDX_W=clog2(SETS), OFF_W=clog2(LINE_WORDS), CNT_W=OFF_W+1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- rd_en  in  1  read request.
- rd_idx  in  IDX_W  set index for the read.
- rd_off  in  OFF_W  word offset within the line for the read.
- rd_data  out  WAYS*DATA_W  read word of every way; way w occupies bits [w*DATA_W +: DATA_W].
- rd_valid  out  1  rd_data holds the result of the previous cycle's rd_en.
- fill_start  in  1  begin refill; sampled only in IDLE.
- fill_way  in  WAY_W  victim way.
- fill_idx  in  IDX_W  set being refilled.
- fill_off  in  OFF_W  first (critical) word offset.
- fill_valid  in  1  refill beat valid.
- fill_data  in  DATA_W  refill beat data.
- fill_ready  out  1  array accepts a beat this cycle.
- fill_busy  out  1  refill in progress.
- fill_done  out  1  one-cycle pulse after the last beat is written.

Behaviour:
- Storage:
  - Each way holds SETS*LINE_WORDS words, word address {idx,off}.
  - Storage is not cleared by rst; contents are undefined until written.
- Read path:
  - One-cycle latency.
  - On rd_en at edge N, rd_data at N+1 = contents at {rd_idx,rd_off} for all ways.
  - rd_valid at N+1 = rd_en at N.
  - Without rd_en, rd_data holds its previous value.
- Fill FSM states: IDLE, FILL, DONE.
  - IDLE:
    - fill_ready=0, fill_busy=0.
    - fill_start=1 latches way/idx/off into f_way/f_idx/f_off, clears beat counter f_cnt=0, then → FILL.
  - FILL:
    - fill_ready=1, fill_busy=1.
    - A beat on fill_valid&&fill_ready writes fill_data to way f_way at {f_idx,f_off}.
    - After the write: f_off=(f_off+1) mod LINE_WORDS (wraps, critical-word-first order); f_cnt++.
    - When the beat is number LINE_WORDS (f_cnt==LINE_WORDS-1 at accept) → DONE.
    - fill_start in FILL is ignored.
    - fill_valid low stalls the FSM indefinitely with no write.
  - DONE:
    - fill_done=1, fill_busy=1, fill_ready=0.
    - Unconditionally → IDLE next cycle.
    - fill_start in DONE is ignored; the earliest new start is sampled in IDLE.
- Collision:
  - Condition: rd_en and an accepted beat in the same cycle, with rd_idx==f_idx and rd_off==f_off.
  - The f_way lane of rd_data returns fill_data (write-first).
  - Other lanes return stored data.
- Reset:
  - rd_data=0, rd_valid=0, fill_done=0, fill_ready=0, fill_busy=0, FSM=IDLE, f_cnt=0.
  - Reset mid-fill aborts the fill with no fill_done. Words already written remain in storage.
- Widths:
  - The offset counter is exactly OFF_W bits, so wrap is natural overflow.
  - f_cnt is CNT_W bits and never exceeds LINE_WORDS-1 in FILL.

Optional Feature:
- Macro: ICACHE_PARITY_EN.
- With the macro defined:
  - Each stored word carries one even-parity bit computed from fill_data at write time.
  - Extra output rd_perr [WAYS], registered alongside rd_data.
  - Bit w is 1 when way w's read word fails parity.
  - Forwarded words never flag an error.
  - rd_perr resets to 0.
- Without the macro: no parity storage and no rd_perr port; behaviour is otherwise identical.

Decomposition:
- Shared package/defines file:
  - Macros for DATA_W default and the WAYS/SETS/LINE_WORDS defaults.
  - Fill FSM state encodings S_IDLE=2'd0, S_FILL=2'd1, S_DONE=2'd2.
  - ICACHE_PARITY_EN switch placed in the config file.
- Sub-module icache_way_ram:
  - One way; single write port, registered read port; parity bit when enabled.
  - Instantiated WAYS times via generate.
  - Forwarding mux and FSM live in icache_data_array.

Test Plan:
- Default params; fill way 1, idx 5, off 3, beats 0xA0..0xA7 back-to-back → writes offsets 3,4,5,6,7,0,1,2; fill_done pulses exactly one cycle after beat 8; reads of idx5 off3 and off2 return 0xA0 and 0xA7 in the way-1 lane.
- fill_valid gapped (beat, 3 idle cycles, beat…) → no writes during gaps; f_off advances only on accepted beats; fill_busy stays 1 until DONE.
- Read idx5 off6 in the same cycle as beat 0xBEEF to way 0, idx5 off6 → next cycle way-0 lane=0xBEEF, way-1 lane=old content; rd_valid=1.
- rst asserted after 4 of 8 beats → next cycle fill_busy=0, fill_ready=0, no fill_done; fresh fill_start is accepted afterwards.
- fill_start held high through FILL and DONE → ignored there; a new fill begins only from IDLE, so fill_busy is 1 for every cycle except the one-cycle IDLE between fills.
- ICACHE_PARITY_EN defined → corrupt the stored parity bit of way 0 idx0 off0 via force; a read there gives rd_perr=2'b01; clean words give 0.

Source files
------------

// File: rtl/icache_data_array_pkg.sv
// Shared defaults and fill-sequencer state encoding for icache_data_array.
// Build option: define ICACHE_PARITY_EN to add per-word even parity and the rd_perr output.
`ifndef ICACHE_DATA_W
`define ICACHE_DATA_W 32
`endif
`ifndef ICACHE_WAYS
`define ICACHE_WAYS 2
`endif
`ifndef ICACHE_SETS
`define ICACHE_SETS 64
`endif
`ifndef ICACHE_LINE_WORDS
`define ICACHE_LINE_WORDS 8
`endif

package icache_data_array_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StDone = 2'd2
  } fill_state_e;

  // Way-select width never collapses to zero, even for a direct-mapped array.
  function automatic int unsigned way_width(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_way_ram.sv
// One cache way: single write port, registered read port, optional per-word parity bit.
// Build option: ICACHE_PARITY_EN adds the stored parity bit and the rpar output.
module icache_way_ram #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
`ifdef ICACHE_PARITY_EN
  ,
  output logic              rpar
`endif
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately left out of reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

`ifdef ICACHE_PARITY_EN
  logic par_q [Depth];
  logic rpar_q;

  always_ff @(posedge clk) begin
    if (we) begin
      par_q[waddr] <= ^wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpar_q <= 1'b0;
    end else if (re) begin
      rpar_q <= par_q[raddr];
    end
  end

  assign rpar = rpar_q;
`endif

endmodule

// File: rtl/icache_data_array.sv
// Multi-way I-cache data store with critical-word-first refill sequencer and write-first forwarding.
// Build option: ICACHE_PARITY_EN adds per-word parity storage and the rd_perr output.
module icache_data_array
  import icache_data_array_pkg::*;
#(
  parameter int unsigned WAYS       = `ICACHE_WAYS,
  parameter int unsigned SETS       = `ICACHE_SETS,
  parameter int unsigned LINE_WORDS = `ICACHE_LINE_WORDS,
  parameter int unsigned DATA_W     = `ICACHE_DATA_W,
  localparam int unsigned WAY_W     = way_width(WAYS),
  localparam int unsigned IDX_W     = $clog2(SETS),
  localparam int unsigned OFF_W     = $clog2(LINE_WORDS),
  localparam int unsigned CNT_W     = OFF_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic [IDX_W-1:0]       rd_idx,
  input  logic [OFF_W-1:0]       rd_off,
  output logic [WAYS*DATA_W-1:0] rd_data,
  output logic                   rd_valid,
`ifdef ICACHE_PARITY_EN
  output logic [WAYS-1:0]        rd_perr,
`endif
  input  logic                   fill_start,
  input  logic [WAY_W-1:0]       fill_way,
  input  logic [IDX_W-1:0]       fill_idx,
  input  logic [OFF_W-1:0]       fill_off,
  input  logic                   fill_valid,
  input  logic [DATA_W-1:0]      fill_data,
  output logic                   fill_ready,
  output logic                   fill_busy,
  output logic                   fill_done
);

  localparam int unsigned ADDR_W = IDX_W + OFF_W;

  fill_state_e      state_q, state_d;
  logic [WAY_W-1:0] f_way_q, f_way_d;
  logic [IDX_W-1:0] f_idx_q, f_idx_d;
  logic [OFF_W-1:0] f_off_q, f_off_d;
  logic [CNT_W-1:0] f_cnt_q, f_cnt_d;

  logic              beat_acc;
  logic              collide;
  logic [WAYS-1:0]   fwd_d, fwd_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic              rd_valid_q;

  assign beat_acc = (state_q == StFill) && fill_valid;
  assign collide  = rd_en && beat_acc && (rd_idx == f_idx_q) && (rd_off == f_off_q);

  always_comb begin
    state_d = state_q;
    f_way_d = f_way_q;
    f_idx_d = f_idx_q;
    f_off_d = f_off_q;
    f_cnt_d = f_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (fill_start) begin
          f_way_d = fill_way;
          f_idx_d = fill_idx;
          f_off_d = fill_off;
          f_cnt_d = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        if (fill_valid) begin
          // Offset wraps by natural overflow, giving critical-word-first order.
          f_off_d = f_off_q + OFF_W'(1);
          f_cnt_d = f_cnt_q + CNT_W'(1);
          if (f_cnt_q == CNT_W'(LINE_WORDS - 1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    fwd_d = '0;
    for (int w = 0; w < WAYS; w++) begin
      fwd_d[w] = collide && (f_way_q == WAY_W'(w));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      f_way_q    <= '0;
      f_idx_q    <= '0;
      f_off_q    <= '0;
      f_cnt_q    <= '0;
      rd_valid_q <= 1'b0;
      fwd_q      <= '0;
      fwd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      f_way_q    <= f_way_d;
      f_idx_q    <= f_idx_d;
      f_off_q    <= f_off_d;
      f_cnt_q    <= f_cnt_d;
      rd_valid_q <= rd_en;
      // Forward selects are held with rd_data when no read is issued.
      if (rd_en) begin
        fwd_q      <= fwd_d;
        fwd_data_q <= fill_data;
      end
    end
  end

  assign rd_valid   = rd_valid_q;
  assign fill_ready = (state_q == StFill);
  assign fill_busy  = (state_q != StIdle);
  assign fill_done  = (state_q == StDone);

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic              way_we;
    logic [DATA_W-1:0] way_rdata;

    assign way_we = beat_acc && !rst && (f_way_q == WAY_W'(w));

`ifdef ICACHE_PARITY_EN
    logic way_rpar;
`endif

    icache_way_ram #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) u_ram (
      .clk  (clk),
      .rst  (rst),
      .we   (way_we),
      .waddr({f_idx_q, f_off_q}),
      .wdata(fill_data),
      .re   (rd_en),
      .raddr({rd_idx, rd_off}),
      .rdata(way_rdata)
`ifdef ICACHE_PARITY_EN
      ,
      .rpar (way_rpar)
`endif
    );

    assign rd_data[w*DATA_W +: DATA_W] = fwd_q[w] ? fwd_data_q : way_rdata;

`ifdef ICACHE_PARITY_EN
    assign rd_perr[w] = !fwd_q[w] && (^{way_rpar, way_rdata});
`endif
  end

`ifndef SYNTHESIS
  cnt_in_range: assert property (@(posedge clk) disable iff (rst)
    (state_q == StFill) |-> (f_cnt_q < CNT_W'(LINE_WORDS)));
  done_one_cycle: assert property (@(posedge clk) disable iff (rst)
    (state_q == StDone) |=> (state_q == StIdle));
`endif

endmodule
